multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_if.sv | 35 +++
 rtl/multicycle_control.sv | 263 ++++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Bus between the multicycle controller and its datapath/memory: instruction bits,
// memory handshake, datapath strobes and the retired-instruction counter.
interface multicycle_control_if;
    logic [10:0] opcode;
    logic        zero;
    logic        mem_ack;
    logic        retired_load;
    logic [15:0] retired_preset;

    logic        mem_req;
    logic        ir_write;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        alu_src;
    logic        mem_to_reg;
    logic        pc_write;
    logic        pc_src;
    logic [2:0]  imm_sel;
    logic [3:0]  alu_ctrl;
    logic        illegal;
    logic [15:0] retired;

    modport slave (
        input  opcode, zero, mem_ack, retired_load, retired_preset,
        output mem_req, ir_write, mem_read, mem_write, reg_write, alu_src,
               mem_to_reg, pc_write, pc_src, imm_sel, alu_ctrl, illegal, retired
    );

    modport master (
        output opcode, zero, mem_ack, retired_load, retired_preset,
        input  mem_req, ir_write, mem_read, mem_write, reg_write, alu_src,
               mem_to_reg, pc_write, pc_src, imm_sel, alu_ctrl, illegal, retired
    );
endinterface

// File: rtl/multicycle_control.sv
// Five-state (FETCH/DECODE/EXEC/MEM/WB) control unit for a LEGv8 subset multicycle
// datapath. Strobes are registered; only IRWrite, STUR completion PCWrite and CBZ PCSrc follow inputs.
module multicycle_control (
    input  logic                clk,
    input  logic                reset_l,
    multicycle_control_if.slave bus
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

    typedef struct packed {
        logic       illegal;
        logic       is_ldur;
        logic       is_stur;
        logic       is_b;
        logic       is_cbz;
        logic       alu_src;
        logic [2:0] imm_sel;
        logic [3:0] alu_ctrl;
    } decode_t;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_LSL   = 4'b0011;
    localparam logic [3:0] ALU_LSR   = 4'b0100;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    localparam logic [2:0] IMM_NONE  = 3'd0;
    localparam logic [2:0] IMM_D     = 3'd1;
    localparam logic [2:0] IMM_CB    = 3'd2;
    localparam logic [2:0] IMM_B     = 3'd3;
    localparam logic [2:0] IMM_SHAMT = 3'd4;
    localparam logic [2:0] IMM_I     = 3'd5;

    function automatic decode_t decode(input logic [10:0] op);
        decode_t d;
        d = '0;
        d.imm_sel = IMM_NONE;
        casez (op)
            11'b10001011000: d.alu_ctrl = ALU_ADD;
            11'b11001011000: d.alu_ctrl = ALU_SUB;
            11'b10001010000: d.alu_ctrl = ALU_AND;
            11'b10101010000: d.alu_ctrl = ALU_ORR;
            11'b11010011011: begin
                d.alu_ctrl = ALU_LSL;
                d.alu_src  = 1'b1;
                d.imm_sel  = IMM_SHAMT;
            end
            11'b11010011010: begin
                d.alu_ctrl = ALU_LSR;
                d.alu_src  = 1'b1;
                d.imm_sel  = IMM_SHAMT;
            end
            11'b1001000100?: begin
                d.alu_ctrl = ALU_ADD;
                d.alu_src  = 1'b1;
                d.imm_sel  = IMM_I;
            end
            11'b1101000100?: begin
                d.alu_ctrl = ALU_SUB;
                d.alu_src  = 1'b1;
                d.imm_sel  = IMM_I;
            end
            11'b1001001000?: begin
                d.alu_ctrl = ALU_AND;
                d.alu_src  = 1'b1;
                d.imm_sel  = IMM_I;
            end
            11'b1011001000?: begin
                d.alu_ctrl = ALU_ORR;
                d.alu_src  = 1'b1;
                d.imm_sel  = IMM_I;
            end
            11'b11111000010: begin
                d.is_ldur  = 1'b1;
                d.alu_ctrl = ALU_ADD;
                d.alu_src  = 1'b1;
                d.imm_sel  = IMM_D;
            end
            11'b11111000000: begin
                d.is_stur  = 1'b1;
                d.alu_ctrl = ALU_ADD;
                d.alu_src  = 1'b1;
                d.imm_sel  = IMM_D;
            end
            11'b10110100???: begin
                d.is_cbz   = 1'b1;
                d.alu_ctrl = ALU_PASSB;
                d.imm_sel  = IMM_CB;
            end
            11'b000101?????: begin
                d.is_b     = 1'b1;
                d.imm_sel  = IMM_B;
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    state_t      state_reg;
    logic [10:0] opcode_reg;
    logic [15:0] retired_reg;
    logic        mem_req_reg;
    logic        mem_read_reg;
    logic        mem_write_reg;
    logic        reg_write_reg;
    logic        alu_src_reg;
    logic        mem_to_reg_reg;
    logic        pc_write_reg;
    logic        pc_src_reg;
    logic        illegal_reg;
    logic [2:0]  imm_sel_reg;
    logic [3:0]  alu_ctrl_reg;

    logic [10:0] dec_op;
    decode_t     dec;
    logic        ack_taken;
    logic        ir_write;
    logic        stur_done;
    logic        pc_write;
    logic        pc_src;
    logic        retire;

    // In FETCH the instruction is still on the bus, so the DECODE-state strobes
    // are prepared from the incoming opcode in the same edge that latches it.
    assign dec_op    = (state_reg == FETCH) ? bus.opcode : opcode_reg;
    assign dec       = decode(dec_op);
    assign ack_taken = mem_req_reg & bus.mem_ack;
    assign ir_write  = (state_reg == FETCH) & ack_taken;
    assign stur_done = (state_reg == MEM) & dec.is_stur & ack_taken;
    assign pc_write  = pc_write_reg | stur_done;
    assign pc_src    = ((state_reg == EXEC) & dec.is_cbz) ? bus.zero : pc_src_reg;
    assign retire    = pc_write & ~illegal_reg;

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state_reg      <= FETCH;
            opcode_reg     <= '0;
            retired_reg    <= '0;
            mem_req_reg    <= 1'b0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            reg_write_reg  <= 1'b0;
            alu_src_reg    <= 1'b0;
            mem_to_reg_reg <= 1'b0;
            pc_write_reg   <= 1'b0;
            pc_src_reg     <= 1'b0;
            illegal_reg    <= 1'b0;
            imm_sel_reg    <= IMM_NONE;
            alu_ctrl_reg   <= '0;
        end else begin
            illegal_reg    <= 1'b0;
            pc_write_reg   <= 1'b0;
            pc_src_reg     <= 1'b0;
            reg_write_reg  <= 1'b0;
            mem_to_reg_reg <= 1'b0;

            if (ir_write) begin
                opcode_reg <= bus.opcode;
            end

            if (bus.retired_load) begin
                retired_reg <= bus.retired_preset;
            end else if (retire) begin
                retired_reg <= retired_reg + 16'd1;
            end

            case (state_reg)
                FETCH: begin
                    // The first FETCH cycle after reset only raises the request.
                    if (ack_taken) begin
                        state_reg    <= DECODE;
                        mem_req_reg  <= 1'b0;
                        mem_read_reg <= 1'b0;
                        imm_sel_reg  <= dec.imm_sel;
                        alu_src_reg  <= dec.alu_src;
                        illegal_reg  <= dec.illegal;
                        pc_write_reg <= dec.illegal;
                    end else begin
                        mem_req_reg  <= 1'b1;
                        mem_read_reg <= 1'b1;
                    end
                end
                DECODE: begin
                    if (dec.illegal) begin
                        state_reg    <= FETCH;
                        mem_req_reg  <= 1'b1;
                        mem_read_reg <= 1'b1;
                    end else begin
                        state_reg    <= EXEC;
                        alu_ctrl_reg <= dec.alu_ctrl;
                        pc_write_reg <= dec.is_b | dec.is_cbz;
                        pc_src_reg   <= dec.is_b;
                    end
                end
                EXEC: begin
                    alu_ctrl_reg <= '0;
                    if (dec.is_b | dec.is_cbz) begin
                        state_reg    <= FETCH;
                        mem_req_reg  <= 1'b1;
                        mem_read_reg <= 1'b1;
                        imm_sel_reg  <= IMM_NONE;
                        alu_src_reg  <= 1'b0;
                    end else if (dec.is_ldur | dec.is_stur) begin
                        state_reg     <= MEM;
                        mem_req_reg   <= 1'b1;
                        mem_read_reg  <= dec.is_ldur;
                        mem_write_reg <= dec.is_stur;
                    end else begin
                        state_reg     <= WB;
                        reg_write_reg <= 1'b1;
                        pc_write_reg  <= 1'b1;
                    end
                end
                MEM: begin
                    if (ack_taken) begin
                        mem_write_reg <= 1'b0;
                        if (dec.is_ldur) begin
                            state_reg      <= WB;
                            mem_req_reg    <= 1'b0;
                            mem_read_reg   <= 1'b0;
                            reg_write_reg  <= 1'b1;
                            mem_to_reg_reg <= 1'b1;
                            pc_write_reg   <= 1'b1;
                        end else begin
                            // STUR retires on the ack cycle and refetches directly.
                            state_reg    <= FETCH;
                            mem_req_reg  <= 1'b1;
                            mem_read_reg <= 1'b1;
                            imm_sel_reg  <= IMM_NONE;
                            alu_src_reg  <= 1'b0;
                        end
                    end
                end
                WB: begin
                    state_reg    <= FETCH;
                    mem_req_reg  <= 1'b1;
                    mem_read_reg <= 1'b1;
                    imm_sel_reg  <= IMM_NONE;
                    alu_src_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= FETCH;
                end
            endcase
        end
    end

    assign bus.mem_req    = mem_req_reg;
    assign bus.ir_write   = ir_write;
    assign bus.mem_read   = mem_read_reg;
    assign bus.mem_write  = mem_write_reg;
    assign bus.reg_write  = reg_write_reg;
    assign bus.alu_src    = alu_src_reg;
    assign bus.mem_to_reg = mem_to_reg_reg;
    assign bus.pc_write   = pc_write;
    assign bus.pc_src     = pc_src;
    assign bus.imm_sel    = imm_sel_reg;
    assign bus.alu_ctrl   = alu_ctrl_reg;
    assign bus.illegal    = illegal_reg;
    assign bus.retired    = retired_reg;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: an instruction-level model builds the expected
// per-cycle outputs, a negedge process compares them, and a few literals pin the model.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic reset_l = 1'b0;
    always #5 clk = ~clk;

    multicycle_control_if bus();

    multicycle_control dut (
        .clk     (clk),
        .reset_l (reset_l),
        .bus     (bus)
    );

    typedef struct packed {
        logic        mem_req;
        logic        ir_write;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        alu_src;
        logic        mem_to_reg;
        logic        pc_write;
        logic        pc_src;
        logic        illegal;
        logic [2:0]  imm_sel;
        logic [3:0]  alu_ctrl;
        logic [15:0] retired;
    } obs_t;

    typedef enum int {K_R, K_SH, K_I, K_LD, K_ST, K_CBZ, K_B, K_ILL} kind_t;

    typedef struct {
        logic [10:0] val;
        logic [10:0] care;
        kind_t       kind;
        logic [3:0]  alu;
    } row_t;

    row_t        tbl [14];
    obs_t        exp_q [$];
    string       tag_q [$];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] retired_model = 16'd0;

    function automatic obs_t sample();
        obs_t a;
        a.mem_req    = bus.mem_req;
        a.ir_write   = bus.ir_write;
        a.mem_read   = bus.mem_read;
        a.mem_write  = bus.mem_write;
        a.reg_write  = bus.reg_write;
        a.alu_src    = bus.alu_src;
        a.mem_to_reg = bus.mem_to_reg;
        a.pc_write   = bus.pc_write;
        a.pc_src     = bus.pc_src;
        a.illegal    = bus.illegal;
        a.imm_sel    = bus.imm_sel;
        a.alu_ctrl   = bus.alu_ctrl;
        a.retired    = bus.retired;
        return a;
    endfunction

    always @(negedge clk) begin
        obs_t  e;
        obs_t  a;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = sample();
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL %s got=%h required=%h", t, a, e);
            end
        end
    end

    task automatic check_lit(input string name, input logic [15:0] got, input logic [15:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    function automatic void lookup(input logic [10:0] op, output kind_t k, output logic [3:0] a);
        k = K_ILL;
        a = 4'b0000;
        for (int i = 0; i < 14; i++) begin
            if ((op & tbl[i].care) == tbl[i].val) begin
                k = tbl[i].kind;
                a = tbl[i].alu;
            end
        end
    endfunction

    function automatic logic [2:0] imm_of(input kind_t k);
        case (k)
            K_LD, K_ST: return 3'd1;
            K_CBZ:      return 3'd2;
            K_B:        return 3'd3;
            K_SH:       return 3'd4;
            K_I:        return 3'd5;
            default:    return 3'd0;
        endcase
    endfunction

    function automatic logic src_of(input kind_t k);
        return (k == K_SH) || (k == K_I) || (k == K_LD) || (k == K_ST);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ack);
        bus.mem_ack      = ack;
        bus.zero         = 1'($urandom);
        bus.opcode       = 11'($urandom);
        bus.retired_load = 1'b0;
    endtask

    task automatic push(input obs_t e, input string t);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic reset_tail(input int n);
        obs_t z;
        z = '0;
        retired_model = 16'd0;
        for (int i = 0; i < n; i++) begin
            step();
            drive(1'b1);
            push(z, "reset_hold");
        end
        step();
        reset_l = 1'b1;
        drive(1'b1);
        push(z, "reset_release");
    endtask

    // Runs one instruction; pc_cyc is the DUT cycle (1-based) in which PCWrite was first seen.
    task automatic run_instr(input string name, input logic [10:0] op, input logic z,
                             input int fw, input int mw, input logic ack_idle,
                             input int abort_at, input logic preset, input int lit_ret,
                             output int pc_cyc, output logic [2:0] dec_imm,
                             output logic [3:0] exec_alu);
        kind_t      k;
        logic [3:0] alu;
        obs_t       e;
        int         n;
        logic       done;
        lookup(op, k, alu);
        n = 0;
        pc_cyc = 0;
        dec_imm = 3'd0;
        exec_alu = 4'd0;
        done = 1'b0;

        for (int i = 0; i <= fw; i++) begin
            step();
            drive(i == fw);
            if (i == fw) bus.opcode = op;
            if (preset && i == 0) begin
                bus.retired_load   = 1'b1;
                bus.retired_preset = 16'hFFFF;
            end
            if (i == 0 && lit_ret >= 0) check_lit({name, "_retired_before"}, bus.retired, 16'(lit_ret));
            e = '0;
            e.retired  = retired_model;
            e.mem_req  = 1'b1;
            e.mem_read = 1'b1;
            e.ir_write = (i == fw);
            push(e, {name, "_fetch"});
            n++;
            #1;
            if (bus.pc_write && pc_cyc == 0) pc_cyc = n;
            if (preset && i == 0) retired_model = 16'hFFFF;
        end

        step();
        drive(ack_idle);
        e = '0;
        e.retired = retired_model;
        if (k == K_ILL) begin
            e.illegal  = 1'b1;
            e.pc_write = 1'b1;
            done = 1'b1;
        end else begin
            e.imm_sel = imm_of(k);
            e.alu_src = src_of(k);
        end
        push(e, {name, "_decode"});
        n++;
        #1;
        dec_imm = bus.imm_sel;
        if (bus.pc_write && pc_cyc == 0) pc_cyc = n;

        if (!done) begin
            step();
            drive(ack_idle);
            bus.zero = z;
            e = '0;
            e.retired  = retired_model;
            e.imm_sel  = imm_of(k);
            e.alu_src  = src_of(k);
            e.alu_ctrl = alu;
            if (k == K_B || k == K_CBZ) begin
                e.pc_write = 1'b1;
                e.pc_src   = (k == K_B) ? 1'b1 : z;
                done = 1'b1;
                retired_model = retired_model + 16'd1;
            end
            push(e, {name, "_exec"});
            n++;
            #1;
            exec_alu = bus.alu_ctrl;
            if (bus.pc_write && pc_cyc == 0) pc_cyc = n;
        end

        if (!done && (k == K_LD || k == K_ST)) begin
            for (int i = 0; i <= mw; i++) begin
                step();
                drive(i == mw);
                e = '0;
                e.retired   = retired_model;
                e.imm_sel   = imm_of(k);
                e.alu_src   = src_of(k);
                e.mem_req   = 1'b1;
                e.mem_read  = (k == K_LD);
                e.mem_write = (k == K_ST);
                if (abort_at == i) begin
                    bus.mem_ack = 1'b0;
                    reset_l = 1'b0;
                    push(e, {name, "_mem_abort"});
                    done = 1'b1;
                    break;
                end
                if (k == K_ST && i == mw) begin
                    e.pc_write = 1'b1;
                    done = 1'b1;
                    retired_model = retired_model + 16'd1;
                end
                push(e, {name, "_mem"});
                n++;
                #1;
                if (bus.pc_write && pc_cyc == 0) pc_cyc = n;
            end
        end

        if (!done) begin
            step();
            drive(ack_idle);
            e = '0;
            e.retired    = retired_model;
            e.imm_sel    = imm_of(k);
            e.alu_src    = src_of(k);
            e.reg_write  = 1'b1;
            e.mem_to_reg = (k == K_LD);
            e.pc_write   = 1'b1;
            retired_model = retired_model + 16'd1;
            push(e, {name, "_wb"});
            n++;
            #1;
            if (bus.pc_write && pc_cyc == 0) pc_cyc = n;
        end

        $display("instr %-6s op=%b cycles=%0d pc_write_cycle=%0d retired_model=%h",
                 name, op, n, pc_cyc, retired_model);
    endtask

    initial begin
        int         pc;
        logic [2:0] im;
        logic [3:0] al;
        int         guard;

        tbl[0]  = '{11'b10001011000, 11'h7FF, K_R,   4'b0010};
        tbl[1]  = '{11'b11001011000, 11'h7FF, K_R,   4'b0110};
        tbl[2]  = '{11'b10001010000, 11'h7FF, K_R,   4'b0000};
        tbl[3]  = '{11'b10101010000, 11'h7FF, K_R,   4'b0001};
        tbl[4]  = '{11'b11010011011, 11'h7FF, K_SH,  4'b0011};
        tbl[5]  = '{11'b11010011010, 11'h7FF, K_SH,  4'b0100};
        tbl[6]  = '{11'b10010001000, 11'h7FE, K_I,   4'b0010};
        tbl[7]  = '{11'b11010001000, 11'h7FE, K_I,   4'b0110};
        tbl[8]  = '{11'b10010010000, 11'h7FE, K_I,   4'b0000};
        tbl[9]  = '{11'b10110010000, 11'h7FE, K_I,   4'b0001};
        tbl[10] = '{11'b11111000010, 11'h7FF, K_LD,  4'b0010};
        tbl[11] = '{11'b11111000000, 11'h7FF, K_ST,  4'b0010};
        tbl[12] = '{11'b10110100000, 11'h7F8, K_CBZ, 4'b0111};
        tbl[13] = '{11'b00010100000, 11'h7E0, K_B,   4'b0000};

        bus.opcode         = '0;
        bus.zero           = 1'b0;
        bus.mem_ack        = 1'b1;
        bus.retired_load   = 1'b0;
        bus.retired_preset = '0;

        reset_tail(2);

        run_instr("ADD",  11'b10001011000, 1'b0, 0, 0, 1'b1, -1, 1'b0, 0, pc, im, al);
        check_lit("add_pc_write_cycle", 16'(pc), 16'd4);
        run_instr("LDUR", 11'b11111000010, 1'b0, 0, 2, 1'b0, -1, 1'b0, 1, pc, im, al);
        check_lit("ldur_pc_write_cycle", 16'(pc), 16'd7);
        check_lit("ldur_imm_sel", 16'(im), 16'd1);
        check_lit("ldur_alu_ctrl", 16'(al), 16'b0010);
        run_instr("CBZ1", 11'b10110100101, 1'b1, 0, 0, 1'b1, -1, 1'b0, 2, pc, im, al);
        check_lit("cbz1_pc_write_cycle", 16'(pc), 16'd3);
        check_lit("cbz1_imm_sel", 16'(im), 16'd2);
        run_instr("CBZ0", 11'b10110100010, 1'b0, 0, 0, 1'b0, -1, 1'b0, 3, pc, im, al);
        check_lit("cbz0_pc_write_cycle", 16'(pc), 16'd3);
        run_instr("ILL1", 11'b11111111111, 1'b0, 0, 0, 1'b1, -1, 1'b0, 4, pc, im, al);
        check_lit("ill_pc_write_cycle", 16'(pc), 16'd2);
        run_instr("ADDI", 11'b10010001001, 1'b0, 1, 0, 1'b0, -1, 1'b0, 4, pc, im, al);
        check_lit("addi_pc_write_cycle", 16'(pc), 16'd5);
        run_instr("SUB",  11'b11001011000, 1'b0, 0, 0, 1'b1, -1, 1'b0, 5, pc, im, al);
        run_instr("AND",  11'b10001010000, 1'b0, 2, 0, 1'b0, -1, 1'b0, -1, pc, im, al);
        run_instr("ORR",  11'b10101010000, 1'b0, 0, 0, 1'b1, -1, 1'b0, -1, pc, im, al);
        run_instr("LSL",  11'b11010011011, 1'b0, 0, 0, 1'b0, -1, 1'b0, -1, pc, im, al);
        check_lit("lsl_alu_ctrl", 16'(al), 16'b0011);
        run_instr("LSR",  11'b11010011010, 1'b0, 0, 0, 1'b1, -1, 1'b0, -1, pc, im, al);
        run_instr("SUBI", 11'b11010001000, 1'b0, 0, 0, 1'b0, -1, 1'b0, -1, pc, im, al);
        run_instr("ANDI", 11'b10010010001, 1'b0, 0, 0, 1'b1, -1, 1'b0, -1, pc, im, al);
        run_instr("ORRI", 11'b10110010000, 1'b0, 0, 0, 1'b0, -1, 1'b0, -1, pc, im, al);
        check_lit("orri_imm_sel", 16'(im), 16'd5);
        run_instr("B",    11'b00010110011, 1'b0, 0, 0, 1'b1, -1, 1'b0, -1, pc, im, al);
        run_instr("STUR", 11'b11111000000, 1'b0, 1, 1, 1'b1, -1, 1'b0, -1, pc, im, al);
        check_lit("stur_pc_write_cycle", 16'(pc), 16'd6);
        run_instr("ILL0", 11'b00000000000, 1'b0, 0, 0, 1'b0, -1, 1'b0, 15, pc, im, al);
        run_instr("STURX", 11'b11111000000, 1'b0, 0, 4, 1'b0, 1, 1'b0, 15, pc, im, al);
        reset_tail(2);
        run_instr("BPRE", 11'b00010100000, 1'b0, 2, 0, 1'b1, -1, 1'b1, 0, pc, im, al);
        run_instr("ADD",  11'b10001011000, 1'b0, 0, 0, 1'b1, -1, 1'b0, 0, pc, im, al);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
